// File: rtl/can_rx_frame.sv
// ---------------------------------------------------------------------------
// can_rx_frame
//
// Receive side of the CAN node. The differential pair is sampled once per
// can_clk rising edge (one bus bit per clock) and standard-format data or
// remote frames are deserialized. Delimiters, EOF and optionally the CRC are
// checked. A good frame is committed to a single-entry valid/ready holding
// register. An ACK-request strobe covers the ACK slot so the node top can
// drive dominant there.
//
// Build option:
//   CAN_RX_CRC_CHECK_EN  when defined, CRC-15 (poly 0x4599, init 0) is
//                        computed over SOF..last data bit and checked
//                        against the received CRC field. When undefined,
//                        the field is only captured. That matches a
//                        transmitter that sends CRC = 0.
//
// Ports:
//   can_clk      bit clock, one bus bit sampled per rising edge
//   reset        synchronous, active-high
//   can_hi_in    CAN-H level
//   can_lo_in    CAN-L level
//   rx_ready     consumer accepts the held frame
//   rx_valid     held frame available
//   rx_id        11-bit identifier
//   rx_rtr       RTR bit
//   rx_dlc       raw DLC field (not clamped)
//   rx_data      data bytes, byte 0 (first on the wire) in [7:0], unused = 0
//   rx_crc       received CRC field
//   ack_drive    request to drive dominant during the ACK slot
//   rx_err       one-cycle error pulse
//   rx_err_code  1 form, 2 CRC, 3 illegal level, 4 extended frame, 5 overrun
//   busy         frame in progress, SOF through EOF
// ---------------------------------------------------------------------------
module can_rx_frame #(
    parameter int IDLE_BITS = 11,
    parameter int MAX_BYTES = 8
) (
    input  logic        can_clk,
    input  logic        reset,
    input  logic        can_hi_in,
    input  logic        can_lo_in,
    input  logic        rx_ready,
    output logic        rx_valid,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic [14:0] rx_crc,
    output logic        ack_drive,
    output logic        rx_err,
    output logic [2:0]  rx_err_code,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF
    } state_t;

    localparam logic [2:0] ERR_FORM    = 3'd1;
`ifdef CAN_RX_CRC_CHECK_EN
    localparam logic [2:0] ERR_CRC     = 3'd2;
`endif
    localparam logic [2:0] ERR_LEVEL   = 3'd3;
    localparam logic [2:0] ERR_EXT     = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_BITS);
    localparam logic [3:0] MAX_SLOTS  = 4'(MAX_BYTES);

    // Number of data bytes actually on the wire for a given DLC.
    function automatic logic [3:0] clamp_bytes(input logic [3:0] dlc);
        clamp_bytes = (dlc > MAX_SLOTS) ? MAX_SLOTS : dlc;
    endfunction

`ifdef CAN_RX_CRC_CHECK_EN
    // One serial step of CRC-15 with polynomial 0x4599.
    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic din);
        logic fb;
        fb = crc[14] ^ din;
        crc_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction
`endif

    // Bus decode. Equal levels read as recessive so that idle or
    // undriven lines never look like a SOF. The frame logic flags
    // them separately while a frame is in progress.
    logic level_bad;
    logic bit_val;
    assign level_bad = (can_hi_in == can_lo_in);
    assign bit_val   = level_bad ? 1'b1 : can_lo_in;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [11:0] arb_q, arb_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;
    logic [14:0] crc_field_q, crc_field_d;

    logic        rx_valid_q, rx_valid_d;
    logic [10:0] rx_id_q, rx_id_d;
    logic        rx_rtr_q, rx_rtr_d;
    logic [3:0]  rx_dlc_q, rx_dlc_d;
    logic [63:0] rx_data_q, rx_data_d;
    logic [14:0] rx_crc_q, rx_crc_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        busy_q, busy_d;

`ifdef CAN_RX_CRC_CHECK_EN
    logic [14:0] crc_calc_q, crc_calc_d;
    logic        crc_bad_q, crc_bad_d;
`endif

    logic        raise;
    logic [2:0]  raise_code;
    logic        commit;
    logic [2:0]  slot;
    logic [7:0]  cur_byte;
    logic [7:0]  data_last;

    // Frame sequencer. The current state names the field that the bit
    // sampled on this edge belongs to. Every check is done on that bit,
    // and every error funnels through raise/raise_code at the bottom.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arb_d       = arb_q;
        dlc_d       = dlc_q;
        data_d      = data_q;
        crc_field_d = crc_field_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        err_code_d  = 3'd0;
        raise       = 1'b0;
        raise_code  = 3'd0;
        commit      = 1'b0;
        slot        = cnt_q[5:3];
        cur_byte    = 8'h00;
        data_last   = 8'h00;
`ifdef CAN_RX_CRC_CHECK_EN
        crc_calc_d  = crc_calc_q;
        crc_bad_d   = crc_bad_q;
`endif

        if (busy_q && level_bad) begin
            raise      = 1'b1;
            raise_code = ERR_LEVEL;
        end else begin
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (!bit_val) begin
                        cnt_d = 8'd0;
                    end else if (cnt_q >= IDLE_LIMIT - 8'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                // Shadow registers are cleared at SOF so that unused
                // data slots read 0 when the frame is committed.
                ST_IDLE: begin
                    if (!bit_val) begin
                        state_d     = ST_ARB;
                        cnt_d       = 8'd0;
                        busy_d      = 1'b1;
                        arb_d       = 12'd0;
                        dlc_d       = 4'd0;
                        data_d      = 64'd0;
                        crc_field_d = 15'd0;
`ifdef CAN_RX_CRC_CHECK_EN
                        crc_calc_d  = crc_step(15'd0, bit_val);
                        crc_bad_d   = 1'b0;
`endif
                    end
                end

                // ID[10:0] then RTR, kept together in one shift register.
                ST_ARB: begin
                    arb_d = {arb_q[10:0], bit_val};
`ifdef CAN_RX_CRC_CHECK_EN
                    crc_calc_d = crc_step(crc_calc_q, bit_val);
`endif
                    if (cnt_q == 8'd11) begin
                        state_d = ST_CTRL;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                // IDE first, then the 4 DLC bits. Remote frames and
                // zero-length frames skip DATA entirely.
                ST_CTRL: begin
`ifdef CAN_RX_CRC_CHECK_EN
                    crc_calc_d = crc_step(crc_calc_q, bit_val);
`endif
                    if (cnt_q == 8'd0) begin
                        if (bit_val) begin
                            raise      = 1'b1;
                            raise_code = ERR_EXT;
                        end else begin
                            cnt_d = 8'd1;
                        end
                    end else begin
                        dlc_d = {dlc_q[2:0], bit_val};
                        if (cnt_q == 8'd4) begin
                            cnt_d = 8'd0;
                            if (!arb_q[0] && (clamp_bytes(dlc_d) != 4'd0)) begin
                                state_d = ST_DATA;
                            end else begin
                                state_d = ST_CRC;
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end

                // cnt_q counts data bits. Its upper bits select the byte
                // slot, so each byte shifts MSB-first into its own slot.
                ST_DATA: begin
                    cur_byte = data_q[{slot, 3'b000} +: 8];
                    data_d[{slot, 3'b000} +: 8] = {cur_byte[6:0], bit_val};
`ifdef CAN_RX_CRC_CHECK_EN
                    crc_calc_d = crc_step(crc_calc_q, bit_val);
`endif
                    data_last = {1'b0, clamp_bytes(dlc_q), 3'b000} - 8'd1;
                    if (cnt_q == data_last) begin
                        state_d = ST_CRC;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                ST_CRC: begin
                    crc_field_d = {crc_field_q[13:0], bit_val};
                    if (cnt_q == 8'd14) begin
                        state_d = ST_CRC_DEL;
                        cnt_d   = 8'd0;
`ifdef CAN_RX_CRC_CHECK_EN
                        crc_bad_d = (crc_field_d != crc_calc_q);
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                // The ACK request is registered here so that it covers
                // exactly the following bit period, which is the ACK slot.
                ST_CRC_DEL: begin
                    if (!bit_val) begin
                        raise      = 1'b1;
                        raise_code = ERR_FORM;
                    end
`ifdef CAN_RX_CRC_CHECK_EN
                    else if (crc_bad_q) begin
                        raise      = 1'b1;
                        raise_code = ERR_CRC;
                    end
`endif
                    else begin
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end

                ST_ACK: begin
                    state_d = ST_ACK_DEL;
                end

                ST_ACK_DEL: begin
                    if (!bit_val) begin
                        raise      = 1'b1;
                        raise_code = ERR_FORM;
                    end else begin
                        state_d = ST_EOF;
                        cnt_d   = 8'd0;
                    end
                end

                // A handshake in the commit cycle frees the holding
                // register, so that case is a normal commit, not an overrun.
                ST_EOF: begin
                    if (!bit_val) begin
                        raise      = 1'b1;
                        raise_code = ERR_FORM;
                    end else if (cnt_q == 8'd6) begin
                        if (rx_valid_q && !rx_ready) begin
                            raise      = 1'b1;
                            raise_code = ERR_OVERRUN;
                        end else begin
                            commit  = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                default: begin
                    state_d = ST_WAIT_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        if (raise) begin
            state_d    = ST_WAIT_IDLE;
            cnt_d      = 8'd0;
            busy_d     = 1'b0;
            ack_d      = 1'b0;
            err_d      = 1'b1;
            err_code_d = raise_code;
        end
    end

    // Holding register: fields change only on commit. A commit always
    // leaves rx_valid set, even when rx_ready consumes the old frame in
    // the same cycle.
    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_id_d    = rx_id_q;
        rx_rtr_d   = rx_rtr_q;
        rx_dlc_d   = rx_dlc_q;
        rx_data_d  = rx_data_q;
        rx_crc_d   = rx_crc_q;
        if (commit) begin
            rx_valid_d = 1'b1;
            rx_id_d    = arb_q[11:1];
            rx_rtr_d   = arb_q[0];
            rx_dlc_d   = dlc_q;
            rx_data_d  = data_q;
            rx_crc_d   = crc_field_q;
        end else if (rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge can_clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_IDLE;
            cnt_q       <= 8'd0;
            arb_q       <= 12'd0;
            dlc_q       <= 4'd0;
            data_q      <= 64'd0;
            crc_field_q <= 15'd0;
            rx_valid_q  <= 1'b0;
            rx_id_q     <= 11'd0;
            rx_rtr_q    <= 1'b0;
            rx_dlc_q    <= 4'd0;
            rx_data_q   <= 64'd0;
            rx_crc_q    <= 15'd0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            busy_q      <= 1'b0;
`ifdef CAN_RX_CRC_CHECK_EN
            crc_calc_q  <= 15'd0;
            crc_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arb_q       <= arb_d;
            dlc_q       <= dlc_d;
            data_q      <= data_d;
            crc_field_q <= crc_field_d;
            rx_valid_q  <= rx_valid_d;
            rx_id_q     <= rx_id_d;
            rx_rtr_q    <= rx_rtr_d;
            rx_dlc_q    <= rx_dlc_d;
            rx_data_q   <= rx_data_d;
            rx_crc_q    <= rx_crc_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
`ifdef CAN_RX_CRC_CHECK_EN
            crc_calc_q  <= crc_calc_d;
            crc_bad_q   <= crc_bad_d;
`endif
        end
    end

    assign rx_valid    = rx_valid_q;
    assign rx_id       = rx_id_q;
    assign rx_rtr      = rx_rtr_q;
    assign rx_dlc      = rx_dlc_q;
    assign rx_data     = rx_data_q;
    assign rx_crc      = rx_crc_q;
    assign ack_drive   = ack_q;
    assign rx_err      = err_q;
    assign rx_err_code = err_code_q;
    assign busy        = busy_q;

endmodule
